fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter / instruction-fetch block.
- Consumes BRANCH_EN from the control decoder, together with the current 9-bit instruction word from instrROM.
- Produces the next instruction address and the run/halt handshake toward the top-level test harness.
- Branch targets are absolute addresses from a small lookup table indexed by an instruction field.

Parameters:
PC_W, 10, width of program counter / instrROM address
LUT_IDX_W, 3, width of branch-target index field (Instruction[5:3]); LUT depth = 2**LUT_IDX_W

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
START  input  1  run request; sampled in IDLE or HALTED only
STALL  input  1  hold PC this cycle (multi-cycle data memory access)
BRANCH_EN  input  1  branch taken, from control decoder
INSTRUCTION  input  9  current machine word at address PC
PC  output  PC_W  instruction address to instrROM
FETCH_VALID  output  1  PC/INSTRUCTION pair is live and will be executed this cycle
DONE  output  1  program halted; held until next START
CYCLE_CNT  output  32  executed-cycle count (only with optional feature)

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (RESET_N).
- All outputs are registered except FETCH_VALID, which is (state==RUN && !STALL).
- Reset values: state=IDLE, PC=0, DONE=0, CYCLE_CNT=0.
- Reset asserted mid-run returns to IDLE immediately. No partial update survives.
- States: IDLE, RUN, HALTED.
- IDLE, START=1: go to RUN, PC<=0, DONE<=0. First fetch is valid the cycle after START is sampled.
- RUN, priority per cycle:
  - STALL: PC held, no state change.
  - Else INSTRUCTION==HALT_INSTR: go to HALTED, DONE<=1, PC held at the halt address.
  - Else BRANCH_EN: PC <= zero-extended branch_lut[INSTRUCTION[5:3]].
  - Else PC <= PC+1, modulo 2**PC_W. PC=all-ones wraps to 0 with no flag.
- Halt beats branch. Stall beats both. A branch under stall is re-evaluated the next cycle from the unchanged INSTRUCTION.
- START during RUN is ignored.
- HALTED: DONE stays 1, PC frozen. START=1 goes to RUN, PC<=0, DONE<=0 the next cycle.
- BRANCH_EN and INSTRUCTION are ignored outside RUN.
- LUT targets are PC_W-bit absolute addresses. An out-of-range index cannot occur (field width == LUT_IDX_W).

Optional Feature:
- Macro: FETCH_CYCLE_CNT_EN.
- Defined:
  - CYCLE_CNT increments on every RUN cycle, including stalled cycles.
  - It clears to 0 when START is accepted and freezes in HALTED.
  - It saturates at 32'hFFFF_FFFF.
- Undefined:
  - The CYCLE_CNT port is still present but tied to 0, and no counter logic is generated.

Decomposition:
- Shared package (definitions):
  - fetch state enum {IDLE, RUN, HALTED}
  - HALT_INSTR = 9'h1FF
  - BR_IDX_MSB=5 / BR_IDX_LSB=3
  - branch-target constant array BR_TARGETS[0:7]: 0, 12, 37, 64, 101, 150, 200, 511
  - existing opcode/fn codes are reused unchanged
- Sub-module branch_lut: combinational index -> PC_W target read of BR_TARGETS. It is kept separate so programs retarget without touching fetch_unit.

Test Plan:
- RESET_N low mid-RUN at PC=45 -> same cycle PC=0, DONE=0, state IDLE. No fetch until START.
- START pulse, no branches, INSTRUCTION non-halt -> PC 0,1,2,3 on consecutive cycles with FETCH_VALID=1.
- In RUN at PC=7, BRANCH_EN=1, INSTRUCTION[5:3]=3'd2 -> next PC=37. With STALL=1 the same cycle -> PC stays 7, then 37 after stall drops.
- INSTRUCTION=9'h1FF with BRANCH_EN=1 at PC=20 -> HALTED, DONE=1, PC stays 20. START -> PC=0, DONE=0 next cycle.
- PC at 1023 (PC_W=10), no branch -> next PC=0, state remains RUN.
- With FETCH_CYCLE_CNT_EN: START, 5 RUN cycles including 2 stalled, then halt -> CYCLE_CNT=5 and frozen. Without the macro -> CYCLE_CNT=0 throughout.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the program-counter / instruction-fetch block.
// Holds the state encoding, the halt opcode and the branch-target table.
package fetch_unit_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned LUT_IDX_W  = 3;
    localparam int unsigned LUT_DEPTH  = 1 << LUT_IDX_W;
    localparam int unsigned INSTR_W    = 9;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned BR_IDX_MSB = 5;
    localparam int unsigned BR_IDX_LSB = 3;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Absolute branch targets; entry 0 is the leftmost element.
    localparam logic [0:LUT_DEPTH-1][PC_W-1:0] BR_TARGETS = {
        10'd0, 10'd12, 10'd37, 10'd64, 10'd101, 10'd150, 10'd200, 10'd511
    };

    function automatic logic [PC_W-1:0] pc_next_seq(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup: instruction index field -> absolute PC.
// Kept separate so a program can be retargeted without touching fetch_unit.
module branch_lut
    import fetch_unit_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    assign target = BR_TARGETS[idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencing for the instruction fetch path.
// Optional executed-cycle counter enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               STALL,
    input  logic               BRANCH_EN,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    output logic [PC_W-1:0]    PC,
    output logic               FETCH_VALID,
    output logic               DONE,
    output logic [CNT_W-1:0]   CYCLE_CNT
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] br_target;

    branch_lut u_branch_lut (
        .idx    (INSTRUCTION[BR_IDX_MSB:BR_IDX_LSB]),
        .target (br_target)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    // Priority inside RUN: stall, then halt, then branch, then sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (START) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!STALL) begin
                    if (INSTRUCTION == HALT_INSTR) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else if (BRANCH_EN) begin
                        pc_d = br_target;
                    end else begin
                        pc_d = pc_next_seq(pc_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign PC          = pc_q;
    assign DONE        = done_q;
    assign FETCH_VALID = (state_q == ST_RUN) && !STALL;

`ifdef FETCH_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counts every RUN cycle (stalled ones too), saturating; cleared on START accept.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_RUN) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (START) begin
            cnt_d = '0;
        end
    end

    assign CYCLE_CNT = cnt_q;
`else
    assign CYCLE_CNT = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural model checked every cycle plus literal pins.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic       STALL = 1'b0;
    logic       BRANCH_EN = 1'b0;
    logic [8:0] INSTRUCTION = 9'h000;
    logic [9:0] PC;
    logic       FETCH_VALID;
    logic       DONE;
    logic [31:0] CYCLE_CNT;

    int n_cmp = 0;
    int n_fail = 0;

    fetch_unit dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .STALL       (STALL),
        .BRANCH_EN   (BRANCH_EN),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .FETCH_VALID (FETCH_VALID),
        .DONE        (DONE),
        .CYCLE_CNT   (CYCLE_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a running flag, a PC number and a counter.
    int          targets [8] = '{0, 12, 37, 64, 101, 150, 200, 511};
    bit          m_run  = 1'b0;
    int          m_pc   = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_cnt  = 32'd0;
`ifdef FETCH_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_run = 1'b0; m_pc = 0; m_done = 1'b0; m_cnt = 32'd0;
        end else if (m_run) begin
            if (CNT_ON && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (!STALL) begin
                if (INSTRUCTION == 9'h1FF) begin
                    m_run = 1'b0; m_done = 1'b1;
                end else if (BRANCH_EN) begin
                    m_pc = targets[int'(INSTRUCTION[5:3])];
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end else if (START) begin
            m_run = 1'b1; m_pc = 0; m_done = 1'b0;
            if (CNT_ON) m_cnt = 32'd0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("pc",    32'(PC),          32'(m_pc));
        chk("done",  32'(DONE),        32'(m_done));
        chk("valid", 32'(FETCH_VALID), 32'(m_run && !STALL));
        chk("cnt",   CYCLE_CNT,        m_cnt);
    end

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic step(input bit st, input bit sl, input bit br, input logic [8:0] ins);
        START = st; STALL = sl; BRANCH_EN = br; INSTRUCTION = ins;
        @(posedge CLK); #1;
    endtask

    function automatic logic [8:0] br_ins(input int idx);
        return 9'(idx << 3);
    endfunction

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc",    32'(PC), 32'd0);
        chk("rst_done",  32'(DONE), 32'd0);
        chk("rst_valid", 32'(FETCH_VALID), 32'd0);
        chk("rst_cnt",   CYCLE_CNT, 32'd0);
        RESET_N = 1'b1;

        step(0, 0, 1, br_ins(2));
        chk("idle_ignores_branch", 32'(PC), 32'd0);

        step(1, 0, 0, 9'h000);
        chk("start_pc0", 32'(PC), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 9'h000);
            chk("seq_pc", 32'(PC), 32'(i));
        end
        step(1, 0, 0, 9'h000);
        chk("start_in_run_ignored", 32'(PC), 32'd4);
        repeat (3) step(0, 0, 0, 9'h000);
        chk("pc7", 32'(PC), 32'd7);

        step(0, 1, 1, br_ins(2));
        chk("branch_stalled", 32'(PC), 32'd7);
        step(0, 0, 1, br_ins(2));
        chk("branch_idx2", 32'(PC), 32'd37);
        step(0, 0, 1, br_ins(7));
        chk("branch_idx7", 32'(PC), 32'd511);
        step(0, 0, 1, br_ins(5));
        chk("branch_idx5", 32'(PC), 32'd150);
        step(0, 0, 1, br_ins(1));
        chk("branch_idx1", 32'(PC), 32'd12);
        repeat (8) step(0, 0, 0, 9'h000);
        chk("pc20", 32'(PC), 32'd20);

        step(0, 0, 1, 9'h1FF);
        chk("halt_pc", 32'(PC), 32'd20);
        chk("halt_done", 32'(DONE), 32'd1);
        step(0, 0, 1, br_ins(3));
        chk("halted_frozen", 32'(PC), 32'd20);
        step(1, 0, 0, 9'h000);
        chk("restart_pc", 32'(PC), 32'd0);
        chk("restart_done", 32'(DONE), 32'd0);

        step(0, 0, 1, br_ins(7));
        repeat (512) step(0, 0, 0, 9'h000);
        chk("pc_max", 32'(PC), 32'd1023);
        step(0, 0, 0, 9'h000);
        chk("pc_wrap", 32'(PC), 32'd0);
        step(0, 0, 0, 9'h000);
        chk("run_after_wrap", 32'(PC), 32'd1);

        step(0, 0, 1, br_ins(2));
        repeat (8) step(0, 0, 0, 9'h000);
        chk("pc45", 32'(PC), 32'd45);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_pc",    32'(PC), 32'd0);
        chk("async_rst_done",  32'(DONE), 32'd0);
        chk("async_rst_valid", 32'(FETCH_VALID), 32'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        step(0, 0, 0, 9'h000);
        chk("idle_after_rst", 32'(PC), 32'd0);

        step(1, 0, 0, 9'h000);
        chk("cnt_cleared", CYCLE_CNT, 32'd0);
        step(0, 0, 0, 9'h000);
        step(0, 1, 0, 9'h000);
        step(0, 1, 0, 9'h000);
        step(0, 0, 0, 9'h000);
        step(0, 0, 0, 9'h1FF);
        chk("cnt_halt_pc", 32'(PC), 32'd2);
        repeat (3) step(0, 0, 0, 9'h000);
        chk("cnt_frozen", CYCLE_CNT, CNT_ON ? 32'd5 : 32'd0);
        chk("cnt_done", 32'(DONE), 32'd1);

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
